// File: rtl/zap_wb_walk_arb.sv
// ----------------------------------------------------------------------------
// zap_wb_walk_arb
//
// This block arbitrates two Wishbone masters onto one shared Wishbone bus.
//   - Master 0 is the page-table walker.
//   - Master 1 is the cache line-fill FSM.
//
// Once a master owns the bus, it keeps it for as long as its cyc stays high.
// A multi-beat burst is therefore never split. At least one IDLE cycle always
// separates two owners.
//
// Tie-break (both cyc high while IDLE):
//   FIXED_PRIO = 0 : round-robin. The master that was not the last owner wins.
//   FIXED_PRIO = 1 : master 0 always wins.
//
// Ports
//   i_clk, i_reset          : clock; synchronous active-high reset
//   i_m0_wb_* / i_m1_wb_*   : master request (cyc, stb, adr, sel, wen, dat)
//   o_m0_wb_* / o_m1_wb_*   : master response (ack gated to owner, dat broadcast)
//   o_wb_*                  : shared bus request, pass-through of the owner
//   i_wb_ack, i_wb_dat      : shared bus response
//   o_grant                 : one-hot owner (01 = m0, 10 = m1, 00 = none)
// ----------------------------------------------------------------------------
module zap_wb_walk_arb #(
    parameter logic FIXED_PRIO = 1'd0
) (
    input  logic        i_clk,
    input  logic        i_reset,

    // Master 0: page walker
    input  logic        i_m0_wb_cyc,
    input  logic        i_m0_wb_stb,
    input  logic [31:0] i_m0_wb_adr,
    input  logic [3:0]  i_m0_wb_sel,
    input  logic        i_m0_wb_wen,
    input  logic [31:0] i_m0_wb_dat,

    // Master 1: cache line FSM
    input  logic        i_m1_wb_cyc,
    input  logic        i_m1_wb_stb,
    input  logic [31:0] i_m1_wb_adr,
    input  logic [3:0]  i_m1_wb_sel,
    input  logic        i_m1_wb_wen,
    input  logic [31:0] i_m1_wb_dat,

    // Master responses
    output logic        o_m0_wb_ack,
    output logic        o_m1_wb_ack,
    output logic [31:0] o_m0_wb_dat,
    output logic [31:0] o_m1_wb_dat,

    // Shared bus request side
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_wen,
    output logic [31:0] o_wb_dat,

    // Shared bus response side
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_dat,

    // Current owner
    output logic [1:0]  o_grant
);

    // State encoding matches the one-hot o_grant value of each state.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GRANT_M0 = 2'b01,
        GRANT_M1 = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;

    // Last owner: 0 = m0, 1 = m1.
    // It resets to m1, so m0 wins the first round-robin tie.
    logic last_q;
    logic last_d;

    // State and last-owner registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold while the owner's cyc is high.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_m0_wb_cyc && i_m1_wb_cyc) begin
                    // Tie: fixed priority, or the master that did not own last.
                    if ((FIXED_PRIO == 1'b1) || (last_q == 1'b1)) begin
                        state_d = GRANT_M0;
                    end else begin
                        state_d = GRANT_M1;
                    end
                end else if (i_m0_wb_cyc) begin
                    state_d = GRANT_M0;
                end else if (i_m1_wb_cyc) begin
                    state_d = GRANT_M1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_M0: begin
                // Stb low with cyc high is a wait state; ownership is kept.
                if (!i_m0_wb_cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else begin
                    state_d = GRANT_M0;
                end
            end
            GRANT_M1: begin
                if (!i_m1_wb_cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else begin
                    state_d = GRANT_M1;
                end
            end
            default: begin
                // Unreachable encoding: propagate X so simulation exposes it.
                state_d = state_t'(2'bxx);
                last_d  = 1'bx;
            end
        endcase
    end

    // Bus mux and ack steering.
    // The bus is a combinational pass-through of the owner, so cyc drops in the
    // same cycle that the owner releases it.
    always_comb begin
        o_wb_cyc    = 1'b0;
        o_wb_stb    = 1'b0;
        o_wb_adr    = 32'h0000_0000;
        o_wb_sel    = 4'h0;
        o_wb_wen    = 1'b0;
        o_wb_dat    = 32'h0000_0000;
        o_m0_wb_ack = 1'b0;
        o_m1_wb_ack = 1'b0;
        o_grant     = 2'b00;
        case (state_q)
            IDLE: begin
                // Bus is quiet. A stray slave ack is dropped here.
                o_grant = 2'b00;
            end
            GRANT_M0: begin
                o_wb_cyc    = i_m0_wb_cyc;
                o_wb_stb    = i_m0_wb_stb;
                o_wb_adr    = i_m0_wb_adr;
                o_wb_sel    = i_m0_wb_sel;
                o_wb_wen    = i_m0_wb_wen;
                o_wb_dat    = i_m0_wb_dat;
                o_m0_wb_ack = i_wb_ack;
                o_grant     = 2'b01;
            end
            GRANT_M1: begin
                o_wb_cyc    = i_m1_wb_cyc;
                o_wb_stb    = i_m1_wb_stb;
                o_wb_adr    = i_m1_wb_adr;
                o_wb_sel    = i_m1_wb_sel;
                o_wb_wen    = i_m1_wb_wen;
                o_wb_dat    = i_m1_wb_dat;
                o_m1_wb_ack = i_wb_ack;
                o_grant     = 2'b10;
            end
            default: begin
                o_wb_cyc    = 1'bx;
                o_wb_stb    = 1'bx;
                o_wb_adr    = {32{1'bx}};
                o_wb_sel    = {4{1'bx}};
                o_wb_wen    = 1'bx;
                o_wb_dat    = {32{1'bx}};
                o_m0_wb_ack = 1'bx;
                o_m1_wb_ack = 1'bx;
                o_grant     = 2'bxx;
            end
        endcase
    end

    // Read data goes to both masters; each master qualifies it with its own ack.
    assign o_m0_wb_dat = i_wb_dat;
    assign o_m1_wb_dat = i_wb_dat;

endmodule

// File: tb/tb_zap_wb_walk_arb.sv
// Directed testbench for zap_wb_walk_arb.
// Two instances share the same stimulus:
//   - dut_a uses round-robin tie-break.
//   - dut_b uses fixed priority.
// Inputs change just after the falling edge. Checks are taken 1 ns later.
module tb_zap_wb_walk_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_wen, m1_cyc, m1_stb, m1_wen;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        wb_ack;
    logic [31:0] wb_dat;

    logic        a_m0_ack, a_m1_ack, a_cyc, a_stb, a_wen;
    logic [31:0] a_m0_dat, a_m1_dat, a_adr, a_dat;
    logic [3:0]  a_sel;
    logic [1:0]  a_grant;
    logic        b_m0_ack, b_m1_ack, b_cyc, b_stb, b_wen;
    logic [31:0] b_m0_dat, b_m1_dat, b_adr, b_dat;
    logic [3:0]  b_sel;
    logic [1:0]  b_grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    zap_wb_walk_arb #(.FIXED_PRIO(1'b0)) dut_a (
        .i_clk(clk), .i_reset(rst),
        .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb), .i_m0_wb_adr(m0_adr),
        .i_m0_wb_sel(m0_sel), .i_m0_wb_wen(m0_wen), .i_m0_wb_dat(m0_dat),
        .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb), .i_m1_wb_adr(m1_adr),
        .i_m1_wb_sel(m1_sel), .i_m1_wb_wen(m1_wen), .i_m1_wb_dat(m1_dat),
        .o_m0_wb_ack(a_m0_ack), .o_m1_wb_ack(a_m1_ack),
        .o_m0_wb_dat(a_m0_dat), .o_m1_wb_dat(a_m1_dat),
        .o_wb_cyc(a_cyc), .o_wb_stb(a_stb), .o_wb_adr(a_adr),
        .o_wb_sel(a_sel), .o_wb_wen(a_wen), .o_wb_dat(a_dat),
        .i_wb_ack(wb_ack), .i_wb_dat(wb_dat), .o_grant(a_grant)
    );

    zap_wb_walk_arb #(.FIXED_PRIO(1'b1)) dut_b (
        .i_clk(clk), .i_reset(rst),
        .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb), .i_m0_wb_adr(m0_adr),
        .i_m0_wb_sel(m0_sel), .i_m0_wb_wen(m0_wen), .i_m0_wb_dat(m0_dat),
        .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb), .i_m1_wb_adr(m1_adr),
        .i_m1_wb_sel(m1_sel), .i_m1_wb_wen(m1_wen), .i_m1_wb_dat(m1_dat),
        .o_m0_wb_ack(b_m0_ack), .o_m1_wb_ack(b_m1_ack),
        .o_m0_wb_dat(b_m0_dat), .o_m1_wb_dat(b_m1_dat),
        .o_wb_cyc(b_cyc), .o_wb_stb(b_stb), .o_wb_adr(b_adr),
        .o_wb_sel(b_sel), .o_wb_wen(b_wen), .o_wb_dat(b_dat),
        .i_wb_ack(wb_ack), .i_wb_dat(wb_dat), .o_grant(b_grant)
    );

    // Stimulus helper: return every input to its idle value.
    task automatic clear_inputs();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_adr = 32'h0; m0_sel = 4'h0;
        m0_wen = 1'b0; m0_dat = 32'h0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_adr = 32'h0; m1_sel = 4'h0;
        m1_wen = 1'b0; m1_dat = 32'h0;
        wb_ack = 1'b0; wb_dat = 32'h0;
    endtask

    // Stimulus helper: hold reset for one rising edge, then release it.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Requests and a slave ack arrive while reset is held high.
        @(negedge clk);
        rst = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1; wb_ack = 1'b1;
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=%b", a_grant, 2'b00); end
        total++; if (a_cyc !== 1'b0) begin bad++; $display("FAIL reset_cyc got=%b exp=0", a_cyc); end
        total++; if (a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0) begin bad++; $display("FAIL reset_acks got=%b%b exp=00", a_m0_ack, a_m1_ack); end
        total++; if (b_grant !== 2'b00) begin bad++; $display("FAIL reset_grant_fixed got=%b exp=00", b_grant); end
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_single_read();
        // Cycle 0: the walker raises its request. The arbiter is still IDLE.
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_4004; m0_sel = 4'hF;
        #1;
        total++; if (a_grant !== 2'b00 || a_cyc !== 1'b0) begin bad++; $display("FAIL rd_c0 got grant=%b cyc=%b exp grant=00 cyc=0", a_grant, a_cyc); end
        // Cycle 1: m0 owns the bus.
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL rd_c1_grant got=%b exp=01", a_grant); end
        total++; if (a_adr !== 32'h0000_4004 || a_sel !== 4'hF || a_stb !== 1'b1) begin bad++; $display("FAIL rd_c1_bus got adr=%h sel=%h stb=%b exp adr=00004004 sel=f stb=1", a_adr, a_sel, a_stb); end
        total++; if (a_m0_ack !== 1'b0) begin bad++; $display("FAIL rd_c1_ack got=%b exp=0", a_m0_ack); end
        // Cycle 2: waiting for the slave.
        @(negedge clk); #1;
        total++; if (a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0) begin bad++; $display("FAIL rd_c2_ack got=%b%b exp=00", a_m0_ack, a_m1_ack); end
        // Cycle 3: the slave acks with read data.
        @(negedge clk);
        wb_ack = 1'b1; wb_dat = 32'hDEAD_0002;
        #1;
        total++; if (a_m0_ack !== 1'b1 || a_m1_ack !== 1'b0) begin bad++; $display("FAIL rd_c3_ack got=%b%b exp=10", a_m0_ack, a_m1_ack); end
        total++; if (a_m0_dat !== 32'hDEAD_0002 || a_m1_dat !== 32'hDEAD_0002) begin bad++; $display("FAIL rd_c3_dat got=%h/%h exp=dead0002", a_m0_dat, a_m1_dat); end
        // Cycle 4: the walker releases. Cyc drops immediately while grant still shows m0.
        @(negedge clk);
        wb_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        #1;
        total++; if (a_cyc !== 1'b0 || a_grant !== 2'b01) begin bad++; $display("FAIL rd_c4_release got cyc=%b grant=%b exp cyc=0 grant=01", a_cyc, a_grant); end
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL rd_c5_idle got=%b exp=00", a_grant); end
    endtask

    task automatic test_stray_ack();
        // A slave ack arriving in IDLE reaches neither master and grants nobody.
        @(negedge clk);
        wb_ack = 1'b1; wb_dat = 32'h1234_5678;
        #1;
        total++; if (a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0) begin bad++; $display("FAIL stray_acks got=%b%b exp=00", a_m0_ack, a_m1_ack); end
        @(negedge clk);
        wb_ack = 1'b0;
        #1;
        total++; if (a_grant !== 2'b00 || a_cyc !== 1'b0) begin bad++; $display("FAIL stray_state got grant=%b cyc=%b exp grant=00 cyc=0", a_grant, a_cyc); end
    endtask

    task automatic test_tie_round_robin();
        apply_reset();
        // First tie after reset: m0 wins.
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_00A0;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_00B1;
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b01 || a_adr !== 32'h0000_00A0) begin bad++; $display("FAIL tie1 got grant=%b adr=%h exp grant=01 adr=000000a0", a_grant, a_adr); end
        // m0 releases while m1 keeps requesting.
        @(negedge clk);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b00 || a_cyc !== 1'b0) begin bad++; $display("FAIL tie1_gap got grant=%b cyc=%b exp grant=00 cyc=0", a_grant, a_cyc); end
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b10 || a_adr !== 32'h0000_00B1) begin bad++; $display("FAIL tie1_m1 got grant=%b adr=%h exp grant=10 adr=000000b1", a_grant, a_adr); end
        // m1 releases, so the last owner is now m1.
        m1_cyc = 1'b0; m1_stb = 1'b0;
        // Second tie: m0 wins again.
        @(negedge clk);
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL tie2 got=%b exp=01", a_grant); end
        // Both release, so the last owner is now m0.
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        // Third tie: m1 wins.
        @(negedge clk);
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b10) begin bad++; $display("FAIL tie3 got=%b exp=10", a_grant); end
        m0_cyc = 1'b0; m1_cyc = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_burst_lock();
        apply_reset();
        // Cycle 0: m1 starts a line-fill write burst.
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_wen = 1'b1; m1_sel = 4'hF;
        m1_adr = 32'h0000_1000; m1_dat = 32'hC0DE_0000;
        m0_adr = 32'h0000_2000;
        // Beats 1..4: the slave acks in every cycle. m0 starts requesting at beat 2.
        for (int beat = 1; beat <= 4; beat++) begin
            @(negedge clk);
            wb_ack = 1'b1;
            m1_adr = 32'h0000_1000 + 32'(beat * 4);
            m1_dat = 32'hC0DE_0000 + 32'(beat);
            if (beat >= 2) begin
                m0_cyc = 1'b1; m0_stb = 1'b1;
            end
            #1;
            total++; if (a_grant !== 2'b10 || a_m1_ack !== 1'b1 || a_m0_ack !== 1'b0) begin bad++; $display("FAIL burst_beat%0d got grant=%b ack=%b%b exp grant=10 ack=01", beat, a_grant, a_m0_ack, a_m1_ack); end
            total++; if (a_adr !== 32'h0000_1000 + 32'(beat * 4) || a_dat !== 32'hC0DE_0000 + 32'(beat) || a_wen !== 1'b1) begin bad++; $display("FAIL burst_bus%0d got adr=%h dat=%h wen=%b", beat, a_adr, a_dat, a_wen); end
        end
        // m1 releases.
        @(negedge clk);
        wb_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_wen = 1'b0;
        #1;
        total++; if (a_cyc !== 1'b0) begin bad++; $display("FAIL burst_release_cyc got=%b exp=0", a_cyc); end
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL burst_gap got=%b exp=00", a_grant); end
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b01 || a_adr !== 32'h0000_2000) begin bad++; $display("FAIL burst_m0_next got grant=%b adr=%h exp grant=01 adr=00002000", a_grant, a_adr); end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wait_state();
        apply_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        @(negedge clk);
        // Stb drops with cyc still high: m0 keeps ownership, and m1's request is ignored.
        m0_stb = 1'b0; m1_cyc = 1'b1;
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b01 || a_cyc !== 1'b1 || a_stb !== 1'b0) begin bad++; $display("FAIL wait_hold got grant=%b cyc=%b stb=%b exp 01/1/0", a_grant, a_cyc, a_stb); end
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_3000;
        @(negedge clk);
        // m0 owns the bus. The ack is pending as reset arrives.
        wb_ack = 1'b1; rst = 1'b1;
        #1;
        total++; if (a_m0_ack !== 1'b1) begin bad++; $display("FAIL rstmid_pre_ack got=%b exp=1", a_m0_ack); end
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b00 || a_cyc !== 1'b0 || a_m0_ack !== 1'b0) begin bad++; $display("FAIL rstmid got grant=%b cyc=%b ack=%b exp 00/0/0", a_grant, a_cyc, a_m0_ack); end
        // m0 keeps cyc high and is granted again after reset.
        rst = 1'b0; wb_ack = 1'b0;
        @(negedge clk); #1;
        total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL rstmid_regrant got=%b exp=01", a_grant); end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed_prio();
        apply_reset();
        // Three ties in a row.
        // The fixed-priority instance always picks m0.
        // The round-robin instance alternates m0, m1, m0.
        for (int t = 0; t < 3; t++) begin
            m0_cyc = 1'b1; m1_cyc = 1'b1;
            @(negedge clk); #1;
            total++; if (b_grant !== 2'b01) begin bad++; $display("FAIL fixed_tie%0d got=%b exp=01", t, b_grant); end
            total++; if (a_grant !== ((t == 1) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_tie%0d got=%b exp=%b", t, a_grant, (t == 1) ? 2'b10 : 2'b01); end
            m0_cyc = 1'b0; m1_cyc = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_stray_ack();
        test_tie_round_robin();
        test_burst_lock();
        test_wait_state();
        test_reset_mid();
        test_fixed_prio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
